// File: rtl/bmd_pm_turnoff_req.sv
// PME_Turn_Off initiator: drains outstanding completions, raises the power-state-change interrupt, then requests PME_TO_Ack.
// Optional ack-wait timeout is built only when BMD_PM_TIMEOUT_EN is defined; otherwise pm_timeout is tied low.
module bmd_pm_turnoff_req #(
  parameter int TCQ            = 1,
  parameter int CNT_W          = 6,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TIMEOUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pm_turnoff_msg,
  input  logic             req_compl,
  input  logic             compl_done,
  input  logic             cfg_power_state_change_ack,
  output logic             cfg_power_state_change_interrupt,
  output logic             pme_to_ack_valid,
  input  logic             pme_to_ack_ready,
  output logic             trn_pending,
  output logic [CNT_W-1:0] outstanding_cnt,
  output logic             pm_done,
  output logic             cnt_err,
  output logic             pm_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_REQ, ST_SEND} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The timeout counter must be able to represent TIMEOUT_CYCLES-1.
  if (TCQ < 0 || (TIMEOUT_W < 31 && (32'd1 << TIMEOUT_W) <= TIMEOUT_CYCLES)) begin : g_bad_param
    $error("bmd_pm_turnoff_req: TIMEOUT_W too small for TIMEOUT_CYCLES");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_bad;

  always_comb begin
    cnt_nxt = outstanding_cnt;
    cnt_bad = 1'b0;
    if (req_compl && !compl_done) begin
      if (outstanding_cnt == CNT_MAX) cnt_bad = 1'b1;
      else                            cnt_nxt = outstanding_cnt + CNT_ONE;
    end else if (compl_done && !req_compl) begin
      if (outstanding_cnt == '0) cnt_bad = 1'b1;
      else                       cnt_nxt = outstanding_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_cnt <= '0;
      trn_pending     <= 1'b0;
      cnt_err         <= 1'b0;
    end else begin
      outstanding_cnt <= cnt_nxt;
      trn_pending     <= (cnt_nxt != '0);
      if (cnt_bad) cnt_err <= 1'b1;
    end
  end

`ifdef BMD_PM_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] tmo_cnt;
`else
  assign pm_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                            <= ST_IDLE;
      cfg_power_state_change_interrupt <= 1'b0;
      pme_to_ack_valid                 <= 1'b0;
      pm_done                          <= 1'b0;
`ifdef BMD_PM_TIMEOUT_EN
      tmo_cnt                          <= '0;
      pm_timeout                       <= 1'b0;
`endif
    end else begin
      pm_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pm_turnoff_msg) state <= ST_DRAIN;
        end
        // A req_compl arriving with the count at zero keeps us draining.
        ST_DRAIN: begin
          if (outstanding_cnt == '0 && !req_compl) begin
            state                            <= ST_REQ;
            cfg_power_state_change_interrupt <= 1'b1;
`ifdef BMD_PM_TIMEOUT_EN
            tmo_cnt                          <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (cfg_power_state_change_ack) begin
            state                            <= ST_SEND;
            cfg_power_state_change_interrupt <= 1'b0;
            pme_to_ack_valid                 <= 1'b1;
          end
`ifdef BMD_PM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state                            <= ST_IDLE;
            cfg_power_state_change_interrupt <= 1'b0;
            pm_timeout                       <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
`endif
        end
        ST_SEND: begin
          if (pme_to_ack_ready) begin
            state            <= ST_IDLE;
            pme_to_ack_valid <= 1'b0;
            pm_done          <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
